trap_controller: RTL

Sequences the precise trap and xRET flow. The commit stage presents the oldest faulting instruction (flagged by the per-instruction privilege/CSR legality check) or a committed MRET/SRET. The block flushes the pipeline, waits for it to drain, issues a single atomic trap-CSR update and changes privilege. It then redirects fetch to the handler or return address. It sits between commit, the CSR file and the frontend redirect port.

---
 rtl/RV.sv | 8 +
 rtl/trap_controller_pkg.sv | 22 ++
 rtl/trap_target_sel.sv | 35 +++
 rtl/trap_controller.sv | 118 +++++++++++
 4 files changed

// File: rtl/RV.sv
// RV: shared RISC-V privilege-level encodings.
package RV;
    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;
endpackage

// File: rtl/trap_controller_pkg.sv
// trap_controller_pkg: FSM states, latched request type and exception cause codes.
package trap_controller_pkg;
    import RV::*;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_UPDATE,
        ST_REDIRECT
    } trap_state_t;
    typedef struct packed {
        logic      is_xret;
        logic      xret_m;
        priv_lvl_t tgt_priv;
    } trap_req_t;
    localparam int unsigned CAUSE_FETCH_MISALIGNED = 0;
    localparam int unsigned CAUSE_FETCH_ACCESS     = 1;
    localparam int unsigned CAUSE_ILLEGAL_INSTR    = 2;
    localparam int unsigned CAUSE_BREAKPOINT       = 3;
    localparam int unsigned CAUSE_ECALL_U          = 8;
    localparam int unsigned CAUSE_ECALL_S          = 9;
    localparam int unsigned CAUSE_ECALL_M          = 11;
endpackage

// File: rtl/trap_target_sel.sv
// trap_target_sel: picks trap target privilege and handler PC.
// DAHU_VECTORED_TVEC_EN enables vectored interrupt dispatch (tvec mode 01).
module trap_target_sel
    import RV::*;
#(
    parameter int XLEN   = 64,
    parameter int NCAUSE = 16
) (
    input  logic [XLEN-1:0]   cause_i,
    input  priv_lvl_t         priv_i,
    input  logic [NCAUSE-1:0] medeleg_i,
    input  logic [XLEN-1:0]   mtvec_i,
    input  logic [XLEN-1:0]   stvec_i,
    output priv_lvl_t         tgt_priv_o,
    output logic [XLEN-1:0]   handler_pc_o
);
    localparam int IW = $clog2(NCAUSE);
    logic            deleg;
    logic [XLEN-1:0] base;
    // Interrupts (MSB set) are never delegated
    assign deleg      = priv_i != PRIV_LVL_M && !cause_i[XLEN-1] &&
                        cause_i < XLEN'(NCAUSE) && medeleg_i[cause_i[IW-1:0]];
    assign tgt_priv_o = deleg ? PRIV_LVL_S : PRIV_LVL_M;
    assign base       = deleg ? {stvec_i[XLEN-1:2], 2'b00} : {mtvec_i[XLEN-1:2], 2'b00};
`ifdef DAHU_VECTORED_TVEC_EN
    logic [1:0] mode;
    assign mode         = deleg ? stvec_i[1:0] : mtvec_i[1:0];
    assign handler_pc_o = (mode == 2'b01 && cause_i[XLEN-1]) ?
                          base + {cause_i[XLEN-3:0], 2'b00} : base;
`else
    logic unused_mode;
    assign unused_mode  = ^{mtvec_i[1:0], stvec_i[1:0]};
    assign handler_pc_o = base;
`endif
endmodule

// File: rtl/trap_controller.sv
// trap_controller: sequences flush, atomic trap/xRET CSR update and fetch redirect.
// DAHU_VECTORED_TVEC_EN selects vectored interrupt handlers in trap_target_sel.
module trap_controller
    import RV::*;
    import trap_controller_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int NCAUSE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_is_xret_i,
    input  logic              req_xret_m_i,
    input  logic [XLEN-1:0]   req_cause_i,
    input  logic [XLEN-1:0]   req_pc_i,
    input  logic [XLEN-1:0]   req_tval_i,
    input  logic [NCAUSE-1:0] medeleg_i,
    input  logic [XLEN-1:0]   mtvec_i,
    input  logic [XLEN-1:0]   stvec_i,
    input  logic [XLEN-1:0]   mepc_i,
    input  logic [XLEN-1:0]   sepc_i,
    input  logic [1:0]        mpp_i,
    input  logic              spp_i,
    input  logic              pipe_empty_i,
    output logic              flush_o,
    output logic              csr_we_o,
    output logic              csr_xret_o,
    output logic [1:0]        csr_tgt_priv_o,
    output logic [XLEN-1:0]   csr_epc_o,
    output logic [XLEN-1:0]   csr_cause_o,
    output logic [XLEN-1:0]   csr_tval_o,
    output logic              redir_valid_o,
    input  logic              redir_ready_i,
    output logic [XLEN-1:0]   redir_pc_o,
    output logic [1:0]        priv_lvl_o
);
    trap_state_t     state_q, state_d;
    trap_req_t       req_q, req_d;
    priv_lvl_t       priv_q, priv_d, sel_priv, xret_priv, new_priv;
    logic [XLEN-1:0] cause_q, cause_d, pc_q, pc_d, tval_q, tval_d, redir_pc_q, redir_pc_d, sel_pc;

    trap_target_sel #(.XLEN(XLEN), .NCAUSE(NCAUSE)) u_sel (
        .cause_i      (req_cause_i),
        .priv_i       (priv_q),
        .medeleg_i    (medeleg_i),
        .mtvec_i      (mtvec_i),
        .stvec_i      (stvec_i),
        .tgt_priv_o   (sel_priv),
        .handler_pc_o (sel_pc)
    );

    // Reserved MPP (2'b10) returns to U
    assign xret_priv = req_q.xret_m ? (mpp_i == 2'b10 ? PRIV_LVL_U : priv_lvl_t'(mpp_i))
                                    : priv_lvl_t'({1'b0, spp_i});
    assign new_priv  = req_q.is_xret ? xret_priv : req_q.tgt_priv;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        priv_d     = priv_q;
        cause_d    = cause_q;
        pc_d       = pc_q;
        tval_d     = tval_q;
        redir_pc_d = redir_pc_q;
        unique case (state_q)
            ST_IDLE: if (req_valid_i) begin
                state_d    = ST_FLUSH;
                req_d      = '{is_xret: req_is_xret_i, xret_m: req_xret_m_i, tgt_priv: sel_priv};
                cause_d    = req_cause_i;
                pc_d       = req_pc_i;
                tval_d     = req_tval_i;
                redir_pc_d = sel_pc;
            end
            ST_FLUSH: if (pipe_empty_i) state_d = ST_UPDATE;
            ST_UPDATE: begin
                state_d    = ST_REDIRECT;
                priv_d     = new_priv;
                redir_pc_d = req_q.is_xret ? (req_q.xret_m ? mepc_i : sepc_i) : redir_pc_q;
            end
            ST_REDIRECT: if (redir_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            priv_q     <= PRIV_LVL_M;
            cause_q    <= '0;
            pc_q       <= '0;
            tval_q     <= '0;
            redir_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            priv_q     <= priv_d;
            cause_q    <= cause_d;
            pc_q       <= pc_d;
            tval_q     <= tval_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    assign req_ready_o    = state_q == ST_IDLE;
    assign flush_o        = state_q == ST_FLUSH;
    assign csr_we_o       = state_q == ST_UPDATE;
    assign csr_xret_o     = csr_we_o && req_q.is_xret;
    assign csr_tgt_priv_o = new_priv;
    assign csr_epc_o      = pc_q;
    assign csr_cause_o    = cause_q;
    assign csr_tval_o     = tval_q;
    assign redir_valid_o  = state_q == ST_REDIRECT;
    assign redir_pc_o     = redir_pc_q;
    assign priv_lvl_o     = priv_q;
endmodule
